// File: rtl/cpu_pkg.sv
// Shared definitions for the DivMult datapath: divider FSM states and timing constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        FIX  = 3'd2,
        ZERO = 3'd3,
        DONE = 3'd4
    } div_state_t;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_CYCLES  = DIV_WIDTH;
    // Accept cycle to done pulse: WIDTH iterations, one sign-fix cycle, one done cycle.
    localparam int DIV_LATENCY = DIV_CYCLES + 2;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] dmag_ext_s;

    // Compare is done one bit wider so a shifted remainder at or above 2^WIDTH cannot wrap.
    always_comb begin
        rem_sh_s   = {rem, q[WIDTH-1]};
        dmag_ext_s = {1'b0, divisor_mag};
        q_next     = {q[WIDTH-2:0], 1'b0};
        rem_next   = rem_sh_s[WIDTH-1:0];
        if (rem_sh_s >= dmag_ext_s) begin
            rem_next  = WIDTH'(rem_sh_s - dmag_ext_s);
            q_next[0] = 1'b1;
        end else begin
            rem_next  = rem_sh_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider for DIV: quotient to LO, remainder to HI, start/done handshake.
module div_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             by_zero
);

    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(DIV_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Two's-complement magnitude; the most negative value maps to itself as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        mag = v[WIDTH-1] ? (~v + ONE) : v;
    endfunction

    div_state_t       state_r, state_s;
    logic             accept_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r, q_r, dmag_r;
    logic [WIDTH-1:0] rem_step_s, q_step_s;
    logic [WIDTH-1:0] lo_fix_s, hi_fix_s;
    logic             sign_q_r, sign_r_r;
    logic             busy_r, done_r, by_zero_r;
    logic [WIDTH-1:0] hi_r, lo_r;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem_r),
        .q           (q_r),
        .divisor_mag (dmag_r),
        .rem_next    (rem_step_s),
        .q_next      (q_step_s)
    );

    // Next-state logic; a start in DONE is accepted just like one in IDLE.
    always_comb begin
        state_s  = state_r;
        accept_s = start && ((state_r == IDLE) || (state_r == DONE));
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_s = (divisor == '0) ? ZERO : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX:     state_s = DONE;
            ZERO:    state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // Sign correction: truncating quotient, remainder follows the dividend's sign.
    always_comb begin
        lo_fix_s = sign_q_r ? (~q_r + ONE) : q_r;
        hi_fix_s = sign_r_r ? (~rem_r + ONE) : rem_r;
    end

    // State, handshake outputs and divide-by-zero flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            by_zero_r <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN) || (state_s == FIX) || (state_s == ZERO);
            done_r  <= (state_s == DONE);
            if (accept_s) begin
                by_zero_r <= (divisor == '0);
            end else begin
                by_zero_r <= by_zero_r;
            end
        end
    end

    // Iteration datapath: operands latched on accept, one restoring step per RUN cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r    <= '0;
            rem_r    <= '0;
            q_r      <= '0;
            dmag_r   <= '0;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r    <= '0;
            rem_r    <= '0;
            q_r      <= mag(dividend);
            dmag_r   <= mag(divisor);
            sign_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_r <= dividend[WIDTH-1];
        end else if (state_r == RUN) begin
            cnt_r <= cnt_r + CNT_ONE;
            rem_r <= rem_step_s;
            q_r   <= q_step_s;
        end
    end

    // HI/LO only change when a real division finishes, so the zero path keeps old results.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (state_r == FIX) begin
            hi_r <= hi_fix_s;
            lo_r <= lo_fix_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign hi      = hi_r;
    assign lo      = lo_r;
    assign by_zero = by_zero_r;

endmodule

// File: tb/tb_div_seq.sv
// Directed test of div_seq: signs, overflow, divide-by-zero, ignored start, back-to-back, reset abort.
module tb_div_seq;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        by_zero;

    int n_cmp;
    int n_err;

    div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .by_zero  (by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to its done pulse. inj>0 pulses a
    // stray start (with different operands) in that cycle of the run.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic exp_bz, input int exp_lat, input int inj);
        int cyc;
        int busy_low;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0000;
        chk({tag, ".bz_c1"}, {31'd0, by_zero}, {31'd0, exp_bz});
        cyc      = 1;
        busy_low = 0;
        while (!done && cyc < 60) begin
            if (!busy) busy_low++;
            if (cyc == inj) begin
                start    = 1'b1;
                dividend = 32'h0000_0009;
                divisor  = 32'h0000_0000;
            end else begin
                start    = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, cyc, exp_lat);
        chk({tag, ".busy_run"}, busy_low, 32'd0);
        chk({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, ".lo"}, lo, exp_lo);
        chk({tag, ".hi"}, hi, exp_hi);
        chk({tag, ".bz"}, {31'd0, by_zero}, {31'd0, exp_bz});
    endtask

    initial begin
        int stray;
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) tick();
        reset = 1'b1;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.bz", {31'd0, by_zero}, 32'd0);
        tick();

        do_op("p100_7", 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 1'b0, DIV_LATENCY, 0);
        tick();
        chk("p100_7.done_pulse", {31'd0, done}, 32'd0);
        chk("p100_7.hold_lo", lo, 32'h0000_000E);

        do_op("m100_7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, DIV_LATENCY, 0);
        tick();
        do_op("p100_m7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002, 1'b0, DIV_LATENCY, 0);
        tick();
        do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, DIV_LATENCY, 0);
        tick();
        do_op("p7_100", 32'd7, 32'd100, 32'h0000_0000, 32'h0000_0007, 1'b0, DIV_LATENCY, 0);
        tick();

        do_op("pre_zero", 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 1'b0, DIV_LATENCY, 0);
        tick();
        do_op("div0", 32'd5, 32'd0, 32'h0000_000E, 32'h0000_0002, 1'b1, 2, 0);
        tick();
        chk("div0.bz_hold", {31'd0, by_zero}, 32'd1);
        do_op("p9_3", 32'd9, 32'd3, 32'h0000_0003, 32'h0000_0000, 1'b0, DIV_LATENCY, 0);
        tick();

        // Stray start at cycle 10, then a back-to-back request in the DONE cycle.
        do_op("ignored", 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 1'b0, DIV_LATENCY, 10);
        do_op("b2b_0_5", 32'd0, 32'd5, 32'h0000_0000, 32'h0000_0000, 1'b0, DIV_LATENCY, 0);
        tick();

        // Reset held low in cycle 20 of a run aborts it silently.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.hi", hi, 32'd0);
        chk("abort.lo", lo, 32'd0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) stray++;
            tick();
        end
        chk("abort.no_done", stray, 32'd0);
        do_op("after_abort", 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 1'b0, DIV_LATENCY, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
